// File: rtl/switch_alu_pkg.sv
// Shared types and constants for the switch-driven ALU core.
package switch_alu_pkg;

    typedef enum logic [1:0] {
        PH_OPCODE = 2'd0,
        PH_SRC1   = 2'd1,
        PH_SRC2   = 2'd2,
        PH_EXEC   = 2'd3
    } phase_e;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_SHL    = 4'd6;
    localparam logic [3:0] OP_SHR    = 4'd7;
    localparam logic [3:0] OP_MOV    = 4'd8;
    localparam logic [3:0] OP_LDI    = 4'd9;
    localparam logic [3:0] OP_INC    = 4'd10;
    localparam logic [3:0] OP_DEC    = 4'd11;
    localparam logic [3:0] OP_NOP_LO = 4'd12;  // 12..15 are all NOP

    localparam logic [1:0] DM_OPCODE  = 2'd0;
    localparam logic [1:0] DM_REG_ID  = 2'd1;
    localparam logic [1:0] DM_REG_VAL = 2'd2;

endpackage

// File: rtl/switch_alu_core_if.sv
// Switch/button inputs and display/flag outputs of the ALU core.
interface switch_alu_core_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SW_WIDTH = 4
);
    localparam int RW = $clog2(NUM_REGS);

    logic [SW_WIDTH-1:0] inputs;
    logic                step_n;
    logic                show_n;
    logic [1:0]          phase;
    logic [3:0]          opcode;
    logic [RW-1:0]       sel_reg;
    logic [1:0]          disp_mode;
    logic [WIDTH-1:0]    disp_value;
    logic                carry;
    logic                zero;
    logic                done;

    modport master (
        output inputs, step_n, show_n,
        input  phase, opcode, sel_reg, disp_mode, disp_value, carry, zero, done
    );

    modport slave (
        input  inputs, step_n, show_n,
        output phase, opcode, sel_reg, disp_mode, disp_value, carry, zero, done
    );
endinterface

// File: rtl/switch_alu_core_button_conditioner.sv
// Synchronises a raw active-low button, debounces it and emits a
// one-cycle press pulse on the accepted released->pressed change.
module button_conditioner #(
    parameter int DEBOUNCE = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          settle;

    // settle fires on the DEBOUNCE-th consecutive differing cycle
    assign differ = sync_q[1] != level_q;
    assign settle = differ && (cnt_q == CW'(DEBOUNCE - 1));
    assign press  = settle && level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_n};
            if (!differ || settle) cnt_q <= '0;
            else                   cnt_q <= cnt_q + 1'b1;
            if (settle) level_q <= sync_q[1];
        end
    end
endmodule

// File: rtl/switch_alu_core.sv
// Four-phase operator-entry FSM around an N x WIDTH register file and a
// 12-op ALU, stepped by a debounced button and observed via the display outputs.
module switch_alu_core
    import switch_alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SW_WIDTH = 4,
    parameter int DEBOUNCE = 16
) (
    input logic               clock,
    input logic               reset_n,
    switch_alu_core_if.slave  bus
);
    localparam int RW = $clog2(NUM_REGS);

    logic                            step_p, show_p;
    phase_e                          phase_q;
    logic [3:0]                      opcode_q;
    logic [RW-1:0]                   src1_q, src2_q;
    logic [WIDTH-1:0]                imm_q;
    logic                            exec_pending_q;
    logic [NUM_REGS-1:0][WIDTH-1:0]  rf_q;
    logic                            carry_q, zero_q, done_q, show_q;
    logic                            enter_op_d;
    logic [WIDTH+1:0]                alu_d;
    logic [RW-1:0]                   sel_w;
    logic [1:0]                      mode_w;

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_step (
        .clock(clock), .reset_n(reset_n), .btn_n(bus.step_n), .press(step_p)
    );
    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_show (
        .clock(clock), .reset_n(reset_n), .btn_n(bus.show_n), .press(show_p)
    );

    // Returns {write_enable, carry, result}
    function automatic logic [WIDTH+1:0] alu(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a, b, imm);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c, wr;
        s = '0; r = '0; c = 1'b0; wr = 1'b1;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[WIDTH-1:0]; c = s[WIDTH]; end
            OP_SUB: begin r = a - b; c = a < b; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            OP_SHR: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
            OP_MOV: r = b;
            OP_LDI: r = imm;
            OP_INC: begin s = {1'b0, a} + (WIDTH+1)'(1); r = s[WIDTH-1:0]; c = s[WIDTH]; end
            OP_DEC: begin r = a - WIDTH'(1); c = (a == '0); end
            default: wr = 1'b0;
        endcase
        return {wr, c, r};
    endfunction

    assign alu_d = alu(opcode_q, rf_q[src1_q], rf_q[src2_q], imm_q);

    // Staying in or returning to OPCODE clears the show flag, beating a toggle
    assign enter_op_d = (phase_q == PH_OPCODE) ||
                        (phase_q == PH_EXEC && !exec_pending_q && step_p);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q        <= PH_OPCODE;
            opcode_q       <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            imm_q          <= '0;
            exec_pending_q <= 1'b0;
            rf_q           <= '0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            done_q         <= 1'b0;
            show_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                PH_OPCODE: begin
                    opcode_q <= bus.inputs[3:0];
                    if (step_p) phase_q <= PH_SRC1;
                end
                PH_SRC1: begin
                    src1_q <= bus.inputs[RW-1:0];
                    if (step_p) phase_q <= PH_SRC2;
                end
                PH_SRC2: begin
                    src2_q <= bus.inputs[RW-1:0];
                    imm_q  <= WIDTH'(bus.inputs);
                    if (step_p) begin
                        phase_q        <= PH_EXEC;
                        exec_pending_q <= 1'b1;
                    end
                end
                PH_EXEC: begin
                    if (exec_pending_q) begin
                        exec_pending_q <= 1'b0;
                        done_q         <= 1'b1;
                        if (alu_d[WIDTH+1]) begin
                            rf_q[src1_q] <= alu_d[WIDTH-1:0];
                            carry_q      <= alu_d[WIDTH];
                            zero_q       <= (alu_d[WIDTH-1:0] == '0);
                        end
                    end else if (step_p) begin
                        phase_q <= PH_OPCODE;
                    end
                end
                default: phase_q <= PH_OPCODE;
            endcase
            if (enter_op_d)  show_q <= 1'b0;
            else if (show_p) show_q <= ~show_q;
        end
    end

    assign sel_w  = (phase_q == PH_SRC2) ? src2_q : src1_q;
    assign mode_w = (phase_q == PH_OPCODE) ? DM_OPCODE :
                    (show_q ? DM_REG_VAL : DM_REG_ID);

    assign bus.phase      = phase_q;
    assign bus.opcode     = opcode_q;
    assign bus.sel_reg    = sel_w;
    assign bus.disp_mode  = mode_w;
    assign bus.disp_value = (mode_w == DM_REG_VAL) ? rf_q[sel_w] : '0;
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_switch_alu_core.sv
// Self-checking bench: directed scenarios plus random ops against an
// arithmetic reference model of the register file and flags.
module tb_switch_alu_core;
    localparam int W    = 8;
    localparam int NR   = 8;
    localparam int SW   = 4;
    localparam int DB   = 4;
    localparam int MASK = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_total = 0;

    int m_rf[NR];
    bit m_c, m_z;

    switch_alu_core_if #(.WIDTH(W), .NUM_REGS(NR), .SW_WIDTH(SW)) bus ();

    switch_alu_core #(.WIDTH(W), .NUM_REGS(NR), .SW_WIDTH(SW), .DEBOUNCE(DB)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (bus.done === 1'b1) done_total++;

    // Reference model: plain integer arithmetic on the architectural state
    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_rf[i] = 0;
        m_c = 0; m_z = 0;
    endfunction

    function automatic void model_exec(input int op, input int s1, input int sw);
        int a, b, r;
        bit c;
        a = m_rf[s1 % NR]; b = m_rf[sw % NR]; c = 0; r = 0;
        case (op)
            0:  r = a + b;
            1:  begin r = a - b; c = (a < b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~a;
            6:  r = a * 2;
            7:  begin r = a / 2; c = (a % 2) == 1; end
            8:  r = b;
            9:  r = sw & MASK;
            10: r = a + 1;
            11: begin r = a - 1; c = (a == 0); end
            default: return;
        endcase
        if (op == 0 || op == 6 || op == 10) c = (r > MASK);
        r = r & MASK;
        m_rf[s1 % NR] = r;
        m_c = c;
        m_z = (r == 0);
    endfunction

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Holds a button until its effect shows (or a bound expires), then releases
    task automatic press_btn(input bit is_show, output int lat, output int dk);
        logic [1:0] p0, m0;
        p0 = bus.phase; m0 = bus.disp_mode; lat = -1; dk = -1;
        if (is_show) bus.show_n = 1'b0; else bus.step_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (dk < 0 && bus.done === 1'b1) dk = k;
            if (lat < 0 && (is_show ? (bus.disp_mode !== m0) : (bus.phase !== p0))) lat = k;
            if (lat > 0 && k >= lat + 3) break;
        end
        bus.show_n = 1'b1; bus.step_n = 1'b1;
        repeat (DB + 4) tick();
    endtask

    task automatic exec_op(input int op, input int s1, input int sw,
                           output int sel1, output int lat_e, output int dk, output bit ok);
        int lat, d;
        ok = 1;
        bus.inputs = 4'(op);
        press_btn(0, lat, d); ok = ok && (lat > 0);
        bus.inputs = 4'(s1);
        tick();
        sel1 = int'(bus.sel_reg);
        press_btn(0, lat, d); ok = ok && (lat > 0);
        bus.inputs = 4'(sw);
        press_btn(0, lat_e, dk); ok = ok && (lat_e > 0);
        model_exec(op, s1, sw);
    endtask

    task automatic finish_op(output bit ok);
        int lat, d;
        bus.inputs = 4'hF;
        press_btn(0, lat, d);
        ok = (lat > 0);
    endtask

    task automatic show_read(output int mode, output int val, output bit ok);
        int lat, d;
        press_btn(1, lat, d);
        mode = int'(bus.disp_mode); val = int'(bus.disp_value); ok = (lat > 0);
    endtask

    task automatic test_reset();
        int lat, d0;
        bit ok;
        if (bus.phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
        n_tests++;
        if (bus.opcode !== 4'd0) begin n_fail++; $display("FAIL reset_opcode: got %0d want 0", bus.opcode); end
        n_tests++;
        if ({bus.carry, bus.zero, bus.done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.carry, bus.zero, bus.done}); end
        n_tests++;
        if (bus.disp_mode !== 2'd0 || bus.disp_value !== 8'h00) begin n_fail++; $display("FAIL reset_disp: got mode %0d val %0h want 0/0", bus.disp_mode, bus.disp_value); end
        n_tests++;
        // 3-cycle glitch must be ignored
        bus.inputs = 4'hF;
        bus.step_n = 1'b0; repeat (3) tick(); bus.step_n = 1'b1;
        repeat (12) tick();
        n_tests++;
        if (bus.phase !== 2'd0 || done_total != 0) begin n_fail++; $display("FAIL glitch: got phase %0d want 0", bus.phase); end
        // held press: exactly one step, 2+DB cycles after the fall
        lat = -1;
        bus.step_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (lat < 0 && bus.phase !== 2'd0) lat = k;
        end
        n_tests++;
        if (lat != 2 + DB) begin n_fail++; $display("FAIL press_latency: got %0d want %0d", lat, 2 + DB); end
        n_tests++;
        if (bus.phase !== 2'd1) begin n_fail++; $display("FAIL held_phase: got %0d want 1", bus.phase); end
        bus.step_n = 1'b1;
        repeat (12) tick();
        n_tests++;
        if (bus.phase !== 2'd1) begin n_fail++; $display("FAIL release_phase: got %0d want 1", bus.phase); end
        d0 = done_total;
        press_btn(0, lat, lat); press_btn(0, lat, lat); finish_op(ok);
        n_tests++;
        if (!ok || bus.phase !== 2'd0 || done_total - d0 != 1) begin n_fail++; $display("FAIL nop_cycle: got phase %0d done %0d want 0/1", bus.phase, done_total - d0); end
    endtask

    task automatic test_ldi();
        int sel1, le, dk, d0, mode, val;
        bit ok, ok2;
        d0 = done_total;
        exec_op(9, 3, 4'hA, sel1, le, dk, ok);
        n_tests++;
        if (!ok || dk != le + 1) begin n_fail++; $display("FAIL ldi_done_timing: got %0d want %0d", dk, le + 1); end
        n_tests++;
        if (done_total - d0 != 1) begin n_fail++; $display("FAIL ldi_done_count: got %0d want 1", done_total - d0); end
        n_tests++;
        if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL ldi_flags: got c%b z%b want c0 z0", bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (!ok2 || mode != 2 || val != 8'h0A) begin n_fail++; $display("FAIL ldi_rf3: got mode %0d val %0h want 2/0a", mode, val); end
        finish_op(ok);
    endtask

    task automatic test_add_sub();
        int seq_op[10] = '{9, 6, 6, 6, 6, 9, 6, 6, 6, 6};
        int seq_s1[10] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
        int seq_sw[10] = '{4'hF, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        int sel1, le, dk, mode, val;
        bit ok, ok2, all_ok;
        all_ok = 1;
        foreach (seq_op[i]) begin
            exec_op(seq_op[i], seq_s1[i], seq_sw[i], sel1, le, dk, ok);
            finish_op(ok2);
            all_ok = all_ok && ok && ok2;
        end
        n_tests++;
        if (!all_ok) begin n_fail++; $display("FAIL build_sequence: got handshake timeout want none"); end
        exec_op(0, 1, 2, sel1, le, dk, ok);
        n_tests++;
        if (bus.carry !== 1'b1 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_flags: got c%b z%b want c1 z0", bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (val != 8'h10) begin n_fail++; $display("FAIL add_result: got %0h want 10", val); end
        finish_op(ok);
        exec_op(1, 2, 2, sel1, le, dk, ok);
        n_tests++;
        if (bus.carry !== 1'b0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL sub_flags: got c%b z%b want c0 z1", bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (val != 8'h00) begin n_fail++; $display("FAIL sub_result: got %0h want 00", val); end
        finish_op(ok);
    endtask

    task automatic test_boundary();
        int sel1, le, dk, d0, mode, val;
        bit ok, ok2;
        exec_op(11, 4'hA, 0, sel1, le, dk, ok);
        n_tests++;
        if (bus.carry !== 1'b1 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL dec_flags: got c%b z%b want c1 z0", bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (sel1 != 2 || val != 8'hFF) begin n_fail++; $display("FAIL dec_result: got sel %0d val %0h want 2/ff", sel1, val); end
        finish_op(ok);
        repeat (3) begin exec_op(6, 1, 0, sel1, le, dk, ok); finish_op(ok); end
        exec_op(6, 4'h9, 0, sel1, le, dk, ok);
        n_tests++;
        if (bus.carry !== 1'b1 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL shl_flags: got c%b z%b want c1 z1", bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (val != 8'h00) begin n_fail++; $display("FAIL shl_result: got %0h want 00", val); end
        finish_op(ok);
        d0 = done_total;
        exec_op(13, 4'hB, 0, sel1, le, dk, ok);
        n_tests++;
        if (sel1 != 3) begin n_fail++; $display("FAIL src1_wrap: got %0d want 3", sel1); end
        n_tests++;
        if (done_total - d0 != 1 || bus.carry !== 1'b1 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL nop_flags: got done %0d c%b z%b want 1 c1 z1", done_total - d0, bus.carry, bus.zero); end
        show_read(mode, val, ok2);
        n_tests++;
        if (val != 8'h0A) begin n_fail++; $display("FAIL nop_rf3: got %0h want 0a", val); end
        finish_op(ok);
    endtask

    task automatic test_display();
        int lat, d, mode, val;
        bit ok;
        bus.inputs = 4'hF;
        press_btn(0, lat, d);
        bus.inputs = 4'd3;
        tick();
        n_tests++;
        if (bus.disp_mode !== 2'd1 || bus.disp_value !== 8'h00) begin n_fail++; $display("FAIL disp_id: got mode %0d val %0h want 1/0", bus.disp_mode, bus.disp_value); end
        show_read(mode, val, ok);
        n_tests++;
        if (!ok || mode != 2 || val != m_rf[3]) begin n_fail++; $display("FAIL disp_val: got mode %0d val %0h want 2/%0h", mode, val, m_rf[3]); end
        show_read(mode, val, ok);
        n_tests++;
        if (mode != 1) begin n_fail++; $display("FAIL disp_toggle_off: got %0d want 1", mode); end
        show_read(mode, val, ok);
        bus.inputs = 4'hF;
        press_btn(0, lat, d); press_btn(0, lat, d); press_btn(0, lat, d);
        n_tests++;
        if (bus.phase !== 2'd0 || bus.disp_mode !== 2'd0) begin n_fail++; $display("FAIL disp_opcode: got phase %0d mode %0d want 0/0", bus.phase, bus.disp_mode); end
        press_btn(0, lat, d);
        n_tests++;
        if (bus.disp_mode !== 2'd1) begin n_fail++; $display("FAIL show_cleared: got %0d want 1", bus.disp_mode); end
        press_btn(0, lat, d); press_btn(0, lat, d); press_btn(0, lat, d);
    endtask

    task automatic test_reset_mid_exec();
        int lat, d, d0, mode, val;
        bit ok;
        bus.inputs = 4'd9; press_btn(0, lat, d);
        bus.inputs = 4'd4; press_btn(0, lat, d);
        bus.inputs = 4'd5;
        d0 = done_total; lat = -1;
        bus.step_n = 1'b0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            tick();
            if (bus.phase === 2'd3) lat = k;
        end
        reset_n = 1'b0; bus.step_n = 1'b1;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (lat != 2 + DB) begin n_fail++; $display("FAIL exec_entry: got %0d want %0d", lat, 2 + DB); end
        n_tests++;
        if (done_total != d0 || bus.phase !== 2'd0) begin n_fail++; $display("FAIL abort: got done %0d phase %0d want 0/0", done_total - d0, bus.phase); end
        n_tests++;
        if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got c%b z%b want c0 z0", bus.carry, bus.zero); end
        for (int i = 0; i < NR; i++) begin
            bus.inputs = 4'hF; press_btn(0, lat, d);
            bus.inputs = 4'(i); tick();
            show_read(mode, val, ok);
            n_tests++;
            if (!ok || mode != 2 || val != m_rf[i]) begin n_fail++; $display("FAIL abort_rf%0d: got %0h want %0h", i, val, m_rf[i]); end
            bus.inputs = 4'hF;
            press_btn(0, lat, d); press_btn(0, lat, d); press_btn(0, lat, d);
        end
    endtask

    task automatic test_random();
        int op, s1, sw, sel1, le, dk, d0, mode, val;
        bit ok, ok2;
        for (int n = 0; n < 20; n++) begin
            op = $urandom_range(0, 15); s1 = $urandom_range(0, 15); sw = $urandom_range(0, 15);
            d0 = done_total;
            exec_op(op, s1, sw, sel1, le, dk, ok);
            n_tests++;
            if (!ok || done_total - d0 != 1) begin n_fail++; $display("FAIL rnd_done op%0d: got %0d want 1", op, done_total - d0); end
            n_tests++;
            if (bus.carry !== m_c || bus.zero !== m_z) begin n_fail++; $display("FAIL rnd_flags op%0d: got c%b z%b want c%b z%b", op, bus.carry, bus.zero, m_c, m_z); end
            show_read(mode, val, ok2);
            n_tests++;
            if (val != m_rf[s1 % NR]) begin n_fail++; $display("FAIL rnd_rf op%0d r%0d: got %0h want %0h", op, s1 % NR, val, m_rf[s1 % NR]); end
            finish_op(ok);
        end
    endtask

    initial begin
        bus.inputs = '0; bus.step_n = 1'b1; bus.show_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) tick();
        test_reset();
        test_ldi();
        test_add_sub();
        test_boundary();
        test_display();
        test_random();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
